// File: rtl/pipe_run_monitor.sv
// Run controller/monitor for the pipelined processor: arms on start, counts RUN
// cycles and retired ops, stops on HALT_OP or timeout. Optional opcode history via TRACE_HIST_EN.
module pipe_run_monitor #(
  parameter int            OP_W       = 6,
  parameter int            CNT_W      = 32,
  parameter logic [OP_W-1:0] HALT_OP  = {OP_W{1'b1}},
  parameter int            TIMEOUT    = 100000,
  parameter int            HIST_DEPTH = 8
) (
  input  logic                          sysclk,
  input  logic                          rstd,
  input  logic                          start,
  input  logic                          abort,
  input  logic [OP_W-1:0]               op_w,
  input  logic                          op_vld,
  output logic                          busy,
  output logic                          done,
  output logic                          timed_out,
  output logic [CNT_W-1:0]              count,
  output logic [CNT_W-1:0]              retired,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [OP_W-1:0]               hist_op
);

  localparam int IDX_W = $clog2(HIST_DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             done_nxt, timed_out_nxt;
  logic [CNT_W-1:0] count_nxt, retired_nxt;
  logic             hist_clr, hist_wr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge sysclk or negedge rstd) begin
    if (!rstd) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      count     <= '0;
      retired   <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt == ARM) || (state_nxt == RUN);
      done      <= done_nxt;
      timed_out <= timed_out_nxt;
      count     <= count_nxt;
      retired   <= retired_nxt;
    end
  end

  // op_w/op_vld are only looked at in RUN, so unknowns elsewhere cannot leak out.
  always_comb begin
    state_nxt     = state;
    done_nxt      = done;
    timed_out_nxt = timed_out;
    count_nxt     = count;
    retired_nxt   = retired;
    hist_clr      = 1'b0;
    hist_wr       = 1'b0;
    if (abort) begin
      state_nxt     = IDLE;
      done_nxt      = 1'b0;
      timed_out_nxt = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nxt     = ARM;
            done_nxt      = 1'b0;
            timed_out_nxt = 1'b0;
            count_nxt     = '0;
            retired_nxt   = '0;
            hist_clr      = 1'b1;
          end
        end
        ARM: state_nxt = RUN;
        RUN: begin
          count_nxt = sat_inc(count);
          if (op_vld) begin
            hist_wr = 1'b1;
          end
          if (op_vld && (op_w == HALT_OP)) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            if (op_vld) begin
              retired_nxt = sat_inc(retired);
            end
            if ((TIMEOUT != 0) && (count == TO_LAST)) begin
              state_nxt     = DONE;
              timed_out_nxt = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef TRACE_HIST_EN
  logic [OP_W-1:0]  hist_mem [HIST_DEPTH];
  logic [IDX_W-1:0] wr_ptr;
  logic [IDX_W-1:0] rd_ptr;

  always_ff @(posedge sysclk or negedge rstd) begin
    if (!rstd) begin
      wr_ptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (hist_clr) begin
      wr_ptr <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) hist_mem[i] <= '0;
    end else if (hist_wr) begin
      hist_mem[wr_ptr] <= op_w;
      wr_ptr           <= wr_ptr + 1'b1;
    end
  end

  // Newest entry sits just behind the write pointer; wrap is implicit in IDX_W.
  assign rd_ptr  = wr_ptr - IDX_W'(1) - hist_idx;
  assign hist_op = hist_mem[rd_ptr];
`else
  logic hist_unused;
  assign hist_unused = &{1'b0, hist_idx, hist_clr, hist_wr};
  assign hist_op     = '0;
`endif

endmodule
